hbf2_decim: RTL and testbench
=============================

// Module: hbf2_decim
// PURPOSE
//  Second half-band decimation stage of the delta-sigma decimation chain.
//  Takes 33-bit signed samples from the first half-band stage (hbf1) and
//  low-pass filters them with an 11-tap symmetric half-band FIR.
//  Decimates by 2 and emits 33-bit signed samples with a one-cycle valid
//  strobe. Input and output rates are set by valid_in/valid_out, not by clk.
// PARAMETERS
//  W      33  input/output sample width (signed, two's complement)
//  ACC_W  45  internal accumulator width (W + 12; no internal overflow)
//  SHIFT  9   coefficient scale, log2(512); DC gain = 512/512 = 1
// PORTS
//  clk        in   1   system clock (4 MHz in the chain), rising edge
//  rst        in   1   asynchronous, active-low reset
//  in         in   33  signed input sample, sampled when valid_in=1
//  valid_in   in   1   input strobe: one sample accepted per clk with valid_in=1
//  out        out  33  signed filtered, decimated sample
//  valid_out  out  1   single-cycle strobe: out holds a new sample
// BEHAVIOUR
//  - Reset is asynchronous, active-low. While rst=0:
//    - the 10-entry delay line, phase bit, out and valid_out are all 0.
//  - Reset mid-stream discards all history; the next accepted sample is phase 0.
//  - Coefficients h[0..10] = 3,0,-25,0,150,256,150,0,-25,0,3 (sum 512).
//    - Zero taps must not consume adders or multipliers.
//    - Implement with shift-add or symmetric pre-add.
//  - Each clk edge with valid_in=1 does three things:
//    - shifts in into x[n] (x[n-1..n-10] hold history);
//    - toggles phase;
//    - if phase was 1 before the edge, computes y = sum h[k]*x[n-k], k=0..10,
//      using the newly accepted sample as x[n].
//  - Output timing: out is registered on that same edge and valid_out=1 for
//    exactly the following clock cycle.
//    - Latency: 1 clk from the accepting edge.
//    - Outputs occur on the 2nd, 4th, 6th... accepted samples.
//    - N inputs give floor(N/2) outputs.
//  - valid_in=0: delay line and phase hold; valid_out goes 0 at the next edge.
//    out holds its last value.
//  - Back-to-back valid_in (every cycle) is supported with no stall.
//    There is no ready/backpressure signal.
//  - Rounding: acc (ACC_W signed) + 2^(SHIFT-1), then arithmetic shift right SHIFT.
//    - Round half up toward +inf.
//  - Saturation: the result is clamped to [-4294967296, 4294967295] before
//    driving out. No wrap-around is permitted.
//  - Initial history after reset is zeros (start-up transient is not suppressed).
// TESTING
//  1. Reset: hold rst=0 with random in/valid_in -> out=0, valid_out=0 throughout.
//  2. Impulse, odd phase: in=512 as the 2nd accepted sample, rest 0
//     -> out = 3,-25,150,150,-25,3, then 0.
//  3. Impulse, even phase: in=512 as the 1st accepted sample, rest 0
//     -> out = 0,0,256,0,0,...
//  4. DC: constant 1000 for 40 samples -> 20 valid_out pulses;
//     from the 6th output on, out=1000.
//  5. Saturation: +/-4294967295 sign-matched to h (full-scale)
//     -> out=4294967295 (clamped, not wrapped).
//     Negated pattern -> out=-4294967296.
//  6. Gapped valid_in (1 of every 3 cycles) gives the same output sequence
//     as test 4. Asserting rst=0 mid-stream clears the state, and
//     re-running test 2 then reproduces the same outputs.

Source files
------------

// File: rtl/hbf2_decim.sv
// Second half-band decimate-by-2 stage: 11-tap symmetric FIR (3,0,-25,0,150,256,...)
// evaluated with pre-adds and shift-adds on every second accepted sample.
module hbf2_decim #(
  parameter int unsigned W     = 33,
  parameter int unsigned ACC_W = 45,
  parameter int unsigned SHIFT = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] in,
  input  logic                valid_in,
  output logic signed [W-1:0] out,
  output logic                valid_out
);

  localparam int unsigned TAPS = 10;
  localparam logic signed [ACC_W-1:0] HALF    = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) << (W - 1));

  // dly[k] holds x[n-1-k]
  logic signed [W-1:0]     dly [TAPS];
  logic                    phase;

  logic signed [ACC_W-1:0] s0, s2, s4, c5;
  logic signed [ACC_W-1:0] acc, rnd, shr;
  logic signed [W-1:0]     y_c;

  // Symmetric pre-add of the nonzero tap pairs, then constant multiplies as shift-adds
  always_comb begin
    s0  = ACC_W'(in)      + ACC_W'(dly[9]);
    s2  = ACC_W'(dly[1])  + ACC_W'(dly[7]);
    s4  = ACC_W'(dly[3])  + ACC_W'(dly[5]);
    c5  = ACC_W'(dly[4]);
    acc = ((s0 <<< 1) + s0)
        - ((s2 <<< 4) + (s2 <<< 3) + s2)
        + ((s4 <<< 7) + (s4 <<< 4) + (s4 <<< 2) + (s4 <<< 1))
        + (c5 <<< 8);
    rnd = acc + HALF;
    shr = rnd >>> SHIFT;
    if (shr > SAT_MAX) begin
      y_c = W'(SAT_MAX);
    end else if (shr < SAT_MIN) begin
      y_c = W'(SAT_MIN);
    end else begin
      y_c = W'(shr);
    end
  end

  // Delay line, decimation phase and registered output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < TAPS; i++) dly[i] <= '0;
      phase     <= 1'b0;
      out       <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in) begin
        dly[0] <= in;
        for (int i = 1; i < TAPS; i++) dly[i] <= dly[i-1];
        phase <= ~phase;
        if (phase) begin
          out       <= y_c;
          valid_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hbf2_decim.sv
// Directed self-checking bench for hbf2_decim: reset, impulses, DC,
// saturation, gapped strobes and mid-stream reset.
module tb_hbf2_decim;

  localparam logic signed [32:0] MAXV = 33'h0_FFFF_FFFF;
  localparam logic signed [32:0] MINV = 33'h1_0000_0000;
  localparam logic signed [32:0] FS   = 33'sd4294967295;

  logic               clk;
  logic               rst;
  logic signed [32:0] din;
  logic               valid_in;
  logic signed [32:0] dout;
  logic               valid_out;

  int n_cmp;
  int n_err;

  logic signed [32:0] dc_exp [20];
  logic signed [32:0] sat_pat [12];

  hbf2_decim dut (
    .clk      (clk),
    .rst      (rst),
    .in       (din),
    .valid_in (valid_in),
    .out      (dout),
    .valid_out(valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [32:0] obs, input logic signed [32:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic signed [32:0] v, input logic vi);
    din      = v;
    valid_in = vi;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    valid_in = 1'b0;
    din      = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // two back-to-back accepted samples; output expected after the second
  task automatic pair(input string tag, input logic signed [32:0] a,
                      input logic signed [32:0] b, input logic signed [32:0] e);
    step(a, 1'b1);
    chk({tag, "_vo0"}, 33'(valid_out), 33'sd0);
    step(b, 1'b1);
    chk({tag, "_vo1"}, 33'(valid_out), 33'sd1);
    chk({tag, "_out"}, dout, e);
  endtask

  // accepted samples separated by two idle cycles each
  task automatic pair_gap(input string tag, input logic signed [32:0] a,
                          input logic signed [32:0] b, input logic signed [32:0] e,
                          input logic signed [32:0] prev);
    step(a, 1'b1);
    chk({tag, "_vo0a"}, 33'(valid_out), 33'sd0);
    step(33'sd77, 1'b0);
    chk({tag, "_hold"}, dout, prev);
    step(-33'sd5, 1'b0);
    chk({tag, "_gapvo"}, 33'(valid_out), 33'sd0);
    step(b, 1'b1);
    chk({tag, "_vo1"}, 33'(valid_out), 33'sd1);
    chk({tag, "_out"}, dout, e);
    step(33'sd9, 1'b0);
    chk({tag, "_vodrop"}, 33'(valid_out), 33'sd0);
    step(33'sd9, 1'b0);
  endtask

  initial begin
    logic signed [32:0] prev;
    n_cmp = 0;
    n_err = 0;
    rst      = 1'b0;
    din      = '0;
    valid_in = 1'b0;

    dc_exp[0] = 33'sd6;
    dc_exp[1] = -33'sd43;
    dc_exp[2] = 33'sd750;
    dc_exp[3] = 33'sd1043;
    dc_exp[4] = 33'sd994;
    for (int i = 5; i < 20; i++) dc_exp[i] = 33'sd1000;

    for (int i = 0; i < 12; i++) sat_pat[i] = '0;
    sat_pat[1]  = FS;   // x[n-10]
    sat_pat[3]  = -FS;  // x[n-8]
    sat_pat[5]  = FS;   // x[n-6]
    sat_pat[6]  = FS;   // x[n-5]
    sat_pat[7]  = FS;   // x[n-4]
    sat_pat[9]  = -FS;  // x[n-2]
    sat_pat[11] = FS;   // x[n]

    // Reset held with random activity
    for (int i = 0; i < 6; i++) begin
      din      = 33'($urandom);
      valid_in = 1'($urandom);
      @(posedge clk);
      #1;
      chk("rst_out", dout, 33'sd0);
      chk("rst_vo", 33'(valid_out), 33'sd0);
    end
    valid_in = 1'b0;
    rst = 1'b1;

    // Impulse on the odd (2nd) sample
    pair("imp_odd0", 33'sd0, 33'sd512, 33'sd3);
    pair("imp_odd1", 33'sd0, 33'sd0, -33'sd25);
    pair("imp_odd2", 33'sd0, 33'sd0, 33'sd150);
    pair("imp_odd3", 33'sd0, 33'sd0, 33'sd150);
    pair("imp_odd4", 33'sd0, 33'sd0, -33'sd25);
    pair("imp_odd5", 33'sd0, 33'sd0, 33'sd3);
    pair("imp_odd6", 33'sd0, 33'sd0, 33'sd0);

    // Impulse on the even (1st) sample
    do_reset();
    pair("imp_evn0", 33'sd512, 33'sd0, 33'sd0);
    pair("imp_evn1", 33'sd0, 33'sd0, 33'sd0);
    pair("imp_evn2", 33'sd0, 33'sd0, 33'sd256);
    pair("imp_evn3", 33'sd0, 33'sd0, 33'sd0);

    // DC, back-to-back
    do_reset();
    for (int i = 0; i < 20; i++) pair($sformatf("dc%0d", i), 33'sd1000, 33'sd1000, dc_exp[i]);
    step(33'sd0, 1'b0);
    chk("dc_end_vo", 33'(valid_out), 33'sd0);
    chk("dc_end_hold", dout, 33'sd1000);

    // Positive full-scale saturation
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(sat_pat[i], 1'b1);
      chk("sat_vo", 33'(valid_out), 33'((i % 2) == 1));
    end
    chk("sat_pos", dout, MAXV);

    // Negative full-scale saturation, continuing the stream
    for (int i = 0; i < 12; i++) step(-sat_pat[i], 1'b1);
    chk("sat_neg_vo", 33'(valid_out), 33'sd1);
    chk("sat_neg", dout, MINV);

    // Gapped DC stream
    do_reset();
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      pair_gap($sformatf("gap%0d", i), 33'sd1000, 33'sd1000, dc_exp[i], prev);
      prev = dc_exp[i];
    end

    // Mid-stream asynchronous reset, then replay the odd impulse
    do_reset();
    pair("mid0", 33'sd1000, 33'sd1000, 33'sd6);
    pair("mid1", 33'sd1000, 33'sd1000, -33'sd43);
    step(33'sd1000, 1'b1);
    chk("mid_pre_out", dout, -33'sd43);
    valid_in = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("mid_async_out", dout, 33'sd0);
    chk("mid_async_vo", 33'(valid_out), 33'sd0);
    @(posedge clk);
    #1 rst = 1'b1;
    pair("rep0", 33'sd0, 33'sd512, 33'sd3);
    pair("rep1", 33'sd0, 33'sd0, -33'sd25);
    pair("rep2", 33'sd0, 33'sd0, 33'sd150);
    pair("rep3", 33'sd0, 33'sd0, 33'sd150);
    pair("rep4", 33'sd0, 33'sd0, -33'sd25);
    pair("rep5", 33'sd0, 33'sd0, 33'sd3);
    pair("rep6", 33'sd0, 33'sd0, 33'sd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
